wb_regfile_hilo: RTL and testbench

//  Writeback-stage sink: 32x32 GPR file plus HI/LO register pair, updated from the WB-stage outputs.

---
 rtl/wb_regfile_hilo_pkg.sv | 26 ++
 rtl/wb_regfile_hilo_hilo_reg.sv | 41 ++++
 rtl/wb_regfile_hilo.sv | 86 ++++++++
 tb/tb_wb_regfile_hilo.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_hilo_pkg.sv
// Shared definitions for the writeback register file: bus widths, register
// count, the zero word/address and the HI/LO write bundle.
// Optional feature macro: WB_BYPASS_EN (write-first bypass on all read paths).
package wb_regfile_hilo_pkg;

   localparam int reg_num = 32;

   typedef logic [31:0] reg_bus_t;
   typedef logic [4:0]  reg_addr_t;

   localparam reg_bus_t  zero_word    = '0;
   localparam reg_addr_t reg_nop_addr = '0;

   // HI and LO are only ever written as a pair, so they travel together.
   typedef struct packed {
      logic     we;
      reg_bus_t hi;
      reg_bus_t lo;
   } hilo_wr_t;

   // A GPR writeback only commits when enabled and not aimed at $0.
   function automatic logic gpr_wr_valid(input logic wreg, input reg_addr_t wd);
      return wreg && (wd != reg_nop_addr);
   endfunction

endpackage

// File: rtl/wb_regfile_hilo_hilo_reg.sv
// HI/LO register pair: storage, paired write port and read-out mux.
// With WB_BYPASS_EN defined, a write in flight is forwarded to the outputs.
module wb_regfile_hilo_hilo_reg
   import wb_regfile_hilo_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  hilo_wr_t wr,
   output reg_bus_t hi,
   output reg_bus_t lo
);

   reg_bus_t hi_q;
   reg_bus_t lo_q;

   // HI/LO storage: cleared by reset, both halves written together.
   // NOTE: state registers use <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= zero_word;
         lo_q <= zero_word;
      end else if (wr.we) begin
         hi_q <= wr.hi;
         lo_q <= wr.lo;
      end
   end

   // Read-out: registered value, or the incoming write when bypass is built in.
   // NOTE: defaults come first so no path leaves an output unassigned (no latch).
   always_comb begin
      hi = hi_q;
      lo = lo_q;
`ifdef WB_BYPASS_EN
      if (wr.we && !rst) begin
         hi = wr.hi;
         lo = wr.lo;
      end
`endif
   end

endmodule

// File: rtl/wb_regfile_hilo.sv
// Writeback-stage sink: 32x32 GPR file with two combinational read ports,
// HI/LO pair (sub-block) and a committed-writeback counter.
// Optional feature macro: WB_BYPASS_EN (write-first bypass on read ports).
module wb_regfile_hilo
   import wb_regfile_hilo_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       wb_wd,
   input  logic [31:0]      wb_wdata,
   input  logic             wb_wreg,
   input  logic             wb_whilo,
   input  logic [31:0]      wb_hi,
   input  logic [31:0]      wb_lo,
   input  logic             re1,
   input  logic [4:0]       raddr1,
   output logic [31:0]      rdata1,
   input  logic             re2,
   input  logic [4:0]       raddr2,
   output logic [31:0]      rdata2,
   output logic [31:0]      hi_o,
   output logic [31:0]      lo_o,
   output logic [CNT_W-1:0] wb_cnt
);

   reg_bus_t gpr [reg_num];
   logic     gpr_we;
   hilo_wr_t hilo_wr;

   assign gpr_we  = gpr_wr_valid(wb_wreg, wb_wd);
   assign hilo_wr = '{we: wb_whilo, hi: wb_hi, lo: wb_lo};

   // GPR array: whole-file clear on reset, single write port otherwise.
   // NOTE: the array is reset because software relies on all GPRs reading 0
   // after reset; this costs a clear path on every entry, kept deliberately.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < reg_num; i++) gpr[i] <= zero_word;
      end else if (gpr_we) begin
         gpr[wb_wd] <= wb_wdata;
      end
   end

   // Read port 1: zero for reset, disabled port or $0; optional write-first.
   always_comb begin
      rdata1 = zero_word;
      if (!rst && re1 && raddr1 != reg_nop_addr) begin
         rdata1 = gpr[raddr1];
`ifdef WB_BYPASS_EN
         if (gpr_we && raddr1 == wb_wd) rdata1 = wb_wdata;
`endif
      end
   end

   // Read port 2: same rules as port 1.
   always_comb begin
      rdata2 = zero_word;
      if (!rst && re2 && raddr2 != reg_nop_addr) begin
         rdata2 = gpr[raddr2];
`ifdef WB_BYPASS_EN
         if (gpr_we && raddr2 == wb_wd) rdata2 = wb_wdata;
`endif
      end
   end

   // Commit counter: one increment per cycle with any committed writeback;
   // wraps silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_cnt <= '0;
      end else if (gpr_we || wb_whilo) begin
         wb_cnt <= wb_cnt + CNT_W'(1);
      end
   end

   wb_regfile_hilo_hilo_reg hilo_reg (
      .clk (clk),
      .rst (rst),
      .wr  (hilo_wr),
      .hi  (hi_o),
      .lo  (lo_o)
   );

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Self-checking bench for wb_regfile_hilo (counter width 4 to exercise wrap).
// Works for both builds; expectations follow WB_BYPASS_EN when defined.
module tb_wb_regfile_hilo;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       wb_wd;
   logic [31:0]      wb_wdata;
   logic             wb_wreg;
   logic             wb_whilo;
   logic [31:0]      wb_hi;
   logic [31:0]      wb_lo;
   logic             re1;
   logic [4:0]       raddr1;
   logic [31:0]      rdata1;
   logic             re2;
   logic [4:0]       raddr2;
   logic [31:0]      rdata2;
   logic [31:0]      hi_o;
   logic [31:0]      lo_o;
   logic [CNT_W-1:0] wb_cnt;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [31:0] m_gpr [32];
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   int unsigned m_cnt;

   wb_regfile_hilo #(.CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_wd    (wb_wd),
      .wb_wdata (wb_wdata),
      .wb_wreg  (wb_wreg),
      .wb_whilo (wb_whilo),
      .wb_hi    (wb_hi),
      .wb_lo    (wb_lo),
      .re1      (re1),
      .raddr1   (raddr1),
      .rdata1   (rdata1),
      .re2      (re2),
      .raddr2   (raddr2),
      .rdata2   (rdata2),
      .hi_o     (hi_o),
      .lo_o     (lo_o),
      .wb_cnt   (wb_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected read-port value from the current model state and inputs.
   function automatic logic [31:0] m_read(input logic re, input logic [4:0] a);
      if (rst || !re || a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
      if (wb_wreg && a == wb_wd) return wb_wdata;
`endif
      return m_gpr[a];
   endfunction

   function automatic logic [31:0] m_hi_now();
`ifdef WB_BYPASS_EN
      if (wb_whilo && !rst) return wb_hi;
`endif
      return m_hi;
   endfunction

   function automatic logic [31:0] m_lo_now();
`ifdef WB_BYPASS_EN
      if (wb_whilo && !rst) return wb_lo;
`endif
      return m_lo;
   endfunction

   // Compare every output against the model away from the clock edge.
   task automatic check_all(input string tag);
      @(negedge clk);
      check({tag, ".rdata1"}, rdata1, m_read(re1, raddr1));
      check({tag, ".rdata2"}, rdata2, m_read(re2, raddr2));
      check({tag, ".hi_o"}, hi_o, m_hi_now());
      check({tag, ".lo_o"}, lo_o, m_lo_now());
      check({tag, ".wb_cnt"}, 32'(wb_cnt), m_cnt);
   endtask

   // Advance one clock; the model applies the same edge's rules.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
         m_hi  = 32'd0;
         m_lo  = 32'd0;
         m_cnt = 0;
      end else begin
         if (wb_wreg && wb_wd != 5'd0) m_gpr[wb_wd] = wb_wdata;
         if (wb_whilo) begin
            m_hi = wb_hi;
            m_lo = wb_lo;
         end
         if ((wb_wreg && wb_wd != 5'd0) || wb_whilo) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      #1;
   endtask

   task automatic drive(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                        input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                        input logic r1e, input logic [4:0] a1, input logic r2e, input logic [4:0] a2);
      rst      = 1'b0;
      wb_wreg  = wreg;
      wb_wd    = wd;
      wb_wdata = wdata;
      wb_whilo = whilo;
      wb_hi    = hi;
      wb_lo    = lo;
      re1      = r1e;
      raddr1   = a1;
      re2      = r2e;
      raddr2   = a2;
   endtask

   task automatic drive_random();
      logic [4:0] wd;
      wd = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), wd, $urandom(),
            1'($urandom_range(0, 3) == 0), $urandom(), $urandom(),
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)));
   endtask

   typedef struct {
      logic        wreg;
      logic [4:0]  wd;
      logic [31:0] wdata;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [4:0]  raddr1;
      logic        re2;
      logic [4:0]  raddr2;
      logic [31:0] e_r1;
      logic [31:0] e_r2;
      logic [31:0] e_hi;
      logic [31:0] e_lo;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t vecs [6];

   initial begin
      // Directed vectors: write in one cycle, read back in the next (bubble) cycle.
      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 5'd5,  1'b1, 5'd0,
                  32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 4'd1};
      vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 5'd0,  1'b1, 5'd5,
                  32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 4'd1};
      vecs[2] = '{1'b1, 5'd3,  32'h00000055, 1'b1, 32'hA, 32'hB, 5'd3,  1'b1, 5'd5,
                  32'h55, 32'hDEADBEEF, 32'hA, 32'hB, 4'd2};
      vecs[3] = '{1'b0, 5'd3,  32'h00000099, 1'b0, 32'h1, 32'h2, 5'd3,  1'b1, 5'd3,
                  32'h55, 32'h55, 32'hA, 32'hB, 4'd2};
      vecs[4] = '{1'b1, 5'd31, 32'h80000001, 1'b0, 32'h0, 32'h0, 5'd31, 1'b0, 5'd31,
                  32'h80000001, 32'h0, 32'hA, 32'hB, 4'd3};
      vecs[5] = '{1'b0, 5'd9,  32'h12345678, 1'b1, 32'hFFFF0000, 32'h1, 5'd5, 1'b1, 5'd31,
                  32'hDEADBEEF, 32'h80000001, 32'hFFFF0000, 32'h1, 4'd4};

      drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      rst = 1'b1;
      tick();
      tick();

      // Reset state
      drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd1, 1'b1, 5'd31);
      @(negedge clk);
      check("reset.rdata1", rdata1, 32'd0);
      check("reset.rdata2", rdata2, 32'd0);
      check("reset.hi_o", hi_o, 32'd0);
      check("reset.lo_o", lo_o, 32'd0);
      check("reset.wb_cnt", 32'(wb_cnt), 32'd0);
      tick();

      // Table-driven directed vectors
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].wreg, vecs[i].wd, vecs[i].wdata, vecs[i].whilo, vecs[i].hi, vecs[i].lo,
               1'b0, vecs[i].wd, 1'b0, vecs[i].wd);
         @(negedge clk);
         check($sformatf("vec%0d.wr_rdata1_dis", i), rdata1, 32'd0);
         check($sformatf("vec%0d.wr_rdata2_dis", i), rdata2, 32'd0);
         tick();
         drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2);
         @(negedge clk);
         check($sformatf("vec%0d.rdata1", i), rdata1, vecs[i].e_r1);
         check($sformatf("vec%0d.rdata2", i), rdata2, vecs[i].e_r2);
         check($sformatf("vec%0d.hi_o", i), hi_o, vecs[i].e_hi);
         check($sformatf("vec%0d.lo_o", i), lo_o, vecs[i].e_lo);
         check($sformatf("vec%0d.wb_cnt", i), 32'(wb_cnt), 32'(vecs[i].e_cnt));
         tick();
      end

      // Same-cycle hazard on r7 and on HI/LO
      drive(1'b1, 5'd7, 32'h1111, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
      drive(1'b1, 5'd7, 32'h1234, 1'b0, 32'd0, 32'd0, 1'b1, 5'd7, 1'b1, 5'd7);
      @(negedge clk);
`ifdef WB_BYPASS_EN
      check("hazard.rdata2", rdata2, 32'h1234);
      check("hazard.rdata1", rdata1, 32'h1234);
`else
      check("hazard.rdata2", rdata2, 32'h1111);
      check("hazard.rdata1", rdata1, 32'h1111);
`endif
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 32'h77, 32'h88, 1'b0, 5'd7, 1'b1, 5'd7);
      @(negedge clk);
      check("hazard.after_rdata2", rdata2, 32'h1234);
`ifdef WB_BYPASS_EN
      check("hazard.hi_o", hi_o, 32'h77);
      check("hazard.lo_o", lo_o, 32'h88);
`else
      check("hazard.hi_o", hi_o, 32'hFFFF0000);
      check("hazard.lo_o", lo_o, 32'h1);
`endif
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      @(negedge clk);
      check("hazard.hi_after", hi_o, 32'h77);
      check("hazard.lo_after", lo_o, 32'h88);
      check("hazard.wb_cnt", 32'(wb_cnt), 32'd7);
      tick();

      // Reset after random writes: held two cycles, then every address reads 0
      for (int i = 0; i < 20; i++) begin
         drive_random();
         check_all("prereset");
         tick();
      end
      drive(1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 32'h5, 32'h6, 1'b1, 5'd5, 1'b1, 5'd3);
      rst = 1'b1;
      check_all("inreset0");
      tick();
      check_all("inreset1");
      tick();
      for (int a = 0; a < 32; a++) begin
         drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'(a), 1'b1, 5'(31 - a));
         @(negedge clk);
         check($sformatf("postreset.r%0d", a), rdata1, 32'd0);
         check($sformatf("postreset.r%0d_p2", 31 - a), rdata2, 32'd0);
         tick();
      end
      check("postreset.hi_o", hi_o, 32'd0);
      check("postreset.lo_o", lo_o, 32'd0);
      check("postreset.wb_cnt", 32'(wb_cnt), 32'd0);

      // Counter wrap: 16 valid writebacks with read ports disabled
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 5'($urandom_range(1, 31)), $urandom(), 1'($urandom_range(0, 1)),
               $urandom(), $urandom(), 1'b0, 5'($urandom_range(1, 31)), 1'b0, 5'($urandom_range(1, 31)));
         @(negedge clk);
         check($sformatf("wrap%0d.rdata1", i), rdata1, 32'd0);
         check($sformatf("wrap%0d.rdata2", i), rdata2, 32'd0);
         tick();
      end
      drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      @(negedge clk);
      check("wrap.wb_cnt", 32'(wb_cnt), 32'd0);
      tick();

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         drive_random();
         rst = ($urandom_range(0, 49) == 0);
         check_all($sformatf("rand%0d", i));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
